// File: rtl/fpu_op_sequencer.sv
// ----------------------------------------------------------------------------
// fpu_op_sequencer
//   Feeds a free-running fpu datapath from a small operand FIFO. Each operand
//   pair is driven onto the fpu inputs and held for HOLD_CYCLES clocks so at
//   least one complete fpu pass settles. The fpu result is then captured into
//   a valid/ready result register. Saturating counters track how many results
//   carried the OVERFLOW and UNDERFLOW flags.
//
// Ports
//   clock100KHz  in   single clock, posedge
//   reset        in   synchronous, active-high
//   in_valid     in   operand pair offered
//   in_ready     out  FIFO not full
//   in_op_a/b    in   operand pair {sign, exp[5:0], mant[24:0]}
//   fpu_op_a/b   out  registered operands to the fpu
//   fpu_data     in   fpu data_out
//   fpu_status   in   fpu status_out {UNDERFLOW,OVERFLOW,INEXACT,EXACT}
//   res_valid    out  captured result held for the consumer
//   res_ready    in   consumer accepts result
//   res_data     out  captured fpu_data
//   res_status   out  captured fpu_status
//   busy         out  sequencer not idle
//   fifo_count   out  entries in the operand FIFO
//   cnt_ovf      out  saturating count of results with OVERFLOW set
//   cnt_unf      out  saturating count of results with UNDERFLOW set
// ----------------------------------------------------------------------------
module fpu_op_sequencer #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 64,
    parameter int CNT_W       = 8
) (
    input  logic                     clock100KHz,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_op_a,
    input  logic [31:0]              in_op_b,
    output logic [31:0]              fpu_op_a,
    output logic [31:0]              fpu_op_b,
    input  logic [31:0]              fpu_data,
    input  logic [3:0]               fpu_status,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [31:0]              res_data,
    output logic [3:0]               res_status,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         cnt_ovf,
    output logic [CNT_W-1:0]         cnt_unf
);

    localparam int AW = $clog2(DEPTH);
    localparam int HW = $clog2(HOLD_CYCLES);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] LOAD    = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;
    localparam logic [1:0] CAPTURE = 2'd3;

    logic [1:0]    state;
    logic [HW-1:0] hold_cnt;

    // operand FIFO, pair stored as {a, b}
    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    // popped pair waits here for the LOAD cycle
    logic [31:0]   ld_a;
    logic [31:0]   ld_b;

    logic push;
    logic pop;

    assign in_ready   = (count != (AW+1)'(DEPTH));
    assign fifo_count = count;
    assign busy       = (state != IDLE);
    assign push       = in_valid && in_ready;
    // The result slot counts as free when it is empty or being drained this
    // cycle, so back-to-back ops lose no cycle to the handshake.
    assign pop        = (state == IDLE) && (count != '0) && (!res_valid || res_ready);

    // ---------------- FIFO ----------------
    always_ff @(posedge clock100KHz) begin
        if (push)
            mem[wr_ptr] <= {in_op_a, in_op_b};
    end

    always_ff @(posedge clock100KHz) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ld_a   <= '0;
            ld_b   <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                ld_a   <= mem[rd_ptr][63:32];
                ld_b   <= mem[rd_ptr][31:0];
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ---------------- sequencer FSM ----------------
    always_ff @(posedge clock100KHz) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
            fpu_op_a <= '0;
            fpu_op_b <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop)
                        state <= LOAD;
                end
                LOAD: begin
                    fpu_op_a <= ld_a;
                    fpu_op_b <= ld_b;
                    hold_cnt <= '0;
                    state    <= HOLD;
                end
                HOLD: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (hold_cnt == HW'(HOLD_CYCLES - 1))
                        state <= CAPTURE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // ---------------- result register ----------------
    always_ff @(posedge clock100KHz) begin
        if (reset) begin
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_status <= '0;
        end else if (state == CAPTURE) begin
            res_valid  <= 1'b1;
            res_data   <= fpu_data;
            res_status <= fpu_status;
        end else if (res_valid && res_ready) begin
            res_valid  <= 1'b0;
        end
    end

    // ---------------- saturating event counters ----------------
    always_ff @(posedge clock100KHz) begin
        if (reset) begin
            cnt_ovf <= '0;
            cnt_unf <= '0;
        end else if (state == CAPTURE) begin
            if (fpu_status[2] && (cnt_ovf != '1))
                cnt_ovf <= cnt_ovf + 1'b1;
            if (fpu_status[3] && (cnt_unf != '1))
                cnt_unf <= cnt_unf + 1'b1;
        end
    end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fpu_op_sequencer
//   Drives fpu_op_sequencer with directed and $urandom stimulus and compares
//   every output each cycle against a queue-based reference model. The fpu is
//   a stub: data = A ^ B, status from a bench-controlled variable.
// ----------------------------------------------------------------------------
module tb_fpu_op_sequencer;

    localparam int DEPTH = 4;
    localparam int HOLD  = 64;
    localparam int CNT_W = 8;
    localparam int OPLEN = HOLD + 2;   // clocks from pop to capture edge

    logic        clock100KHz = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_op_a, in_op_b;
    logic [31:0] fpu_op_a, fpu_op_b;
    logic [31:0] fpu_data;
    logic [3:0]  fpu_status;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [3:0]  res_status;
    logic        busy;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [CNT_W-1:0] cnt_ovf, cnt_unf;

    logic [3:0] stub_status;

    assign fpu_data   = fpu_op_a ^ fpu_op_b;
    assign fpu_status = stub_status;

    fpu_op_sequencer #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .CNT_W(CNT_W)) dut (
        .clock100KHz (clock100KHz),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op_a     (in_op_a),
        .in_op_b     (in_op_b),
        .fpu_op_a    (fpu_op_a),
        .fpu_op_b    (fpu_op_b),
        .fpu_data    (fpu_data),
        .fpu_status  (fpu_status),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_status  (res_status),
        .busy        (busy),
        .fifo_count  (fifo_count),
        .cnt_ovf     (cnt_ovf),
        .cnt_unf     (cnt_unf)
    );

    always #5 clock100KHz = ~clock100KHz;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            if (nerr <= 40)
                $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] q[$];
    int          busy_left;      // clocks until the in-flight op is captured
    logic [63:0] inflight;
    logic [31:0] m_opa, m_opb, m_data;
    logic [3:0]  m_status;
    logic        m_rv;
    int          m_ovf, m_unf;

    task automatic model_reset();
        q.delete();
        busy_left = 0;
        inflight  = '0;
        m_opa = '0; m_opb = '0; m_data = '0; m_status = '0;
        m_rv  = 1'b0;
        m_ovf = 0;  m_unf = 0;
    endtask

    // Applies one clock edge using the inputs that were stable across it.
    task automatic model_edge();
        bit do_push, do_pop, do_cap, do_load, fire;
        if (reset) begin
            model_reset();
            return;
        end
        do_push = in_valid && (q.size() < DEPTH);
        do_pop  = (busy_left == 0) && (q.size() > 0) && (!m_rv || res_ready);
        do_load = (busy_left == OPLEN);
        do_cap  = (busy_left == 1);
        fire    = m_rv && res_ready;
        if (do_load) begin
            m_opa = inflight[63:32];
            m_opb = inflight[31:0];
        end
        if (do_cap) begin
            m_rv     = 1'b1;
            m_data   = m_opa ^ m_opb;
            m_status = stub_status;
            if (stub_status[2] && m_ovf < 255) m_ovf++;
            if (stub_status[3] && m_unf < 255) m_unf++;
        end else if (fire) begin
            m_rv = 1'b0;
        end
        if (busy_left > 0) busy_left--;
        if (do_pop) begin
            inflight  = q.pop_front();
            busy_left = OPLEN;
        end
        if (do_push) q.push_back({in_op_a, in_op_b});
    endtask

    task automatic compare_all();
        chk("in_ready",   64'(in_ready),   64'(q.size() < DEPTH));
        chk("fifo_count", 64'(fifo_count), 64'(q.size()));
        chk("busy",       64'(busy),       64'(busy_left != 0));
        chk("res_valid",  64'(res_valid),  64'(m_rv));
        chk("res_data",   64'(res_data),   64'(m_data));
        chk("res_status", 64'(res_status), 64'(m_status));
        chk("fpu_op_a",   64'(fpu_op_a),   64'(m_opa));
        chk("fpu_op_b",   64'(fpu_op_b),   64'(m_opb));
        chk("cnt_ovf",    64'(cnt_ovf),    64'(m_ovf));
        chk("cnt_unf",    64'(cnt_unf),    64'(m_unf));
    endtask

    // Inputs are set at the falling edge; one call = one rising edge.
    task automatic tick();
        @(posedge clock100KHz);
        model_edge();
        @(negedge clock100KHz);
        compare_all();
    endtask

    task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1; in_op_a = a; in_op_b = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    initial begin
        int n;
        logic [31:0] held_a;
        reset = 1'b1; in_valid = 1'b0; in_op_a = '0; in_op_b = '0;
        res_ready = 1'b1; stub_status = 4'b0001;
        model_reset();
        @(negedge clock100KHz);

        // reset state
        do_reset(3);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_busy",     64'(busy),     64'd0);

        // 1: single op latency and data
        push_pair(32'h4000_0000, 32'h4200_0000);
        n = 0;
        while (!res_valid && n < 200) begin tick(); n++; end
        chk("latency",      64'(n),          64'd67);
        chk("t1_res_data",  64'(res_data),   64'h0200_0000);
        chk("t1_res_stat",  64'(res_status), 64'h1);
        repeat (5) tick();

        // 2: five back-to-back pushes, drained in order
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_op_a = $urandom; in_op_b = $urandom;
            tick();
        end
        in_valid = 1'b0;
        chk("t2_full", 64'(in_ready), 64'd0);
        repeat (5 * (HOLD + 3) + 20) tick();

        // 3: consumer stalls with a result held
        push_pair($urandom, $urandom);
        n = 0;
        while (!res_valid && n < 200) begin tick(); n++; end
        res_ready = 1'b0;
        held_a = fpu_op_a;
        for (int i = 0; i < 200; i++) begin
            in_valid = 1'b1; in_op_a = $urandom; in_op_b = $urandom;
            tick();
        end
        in_valid = 1'b0;
        chk("t3_fifo_full", 64'(fifo_count), 64'd4);
        chk("t3_op_hold",   64'(fpu_op_a),   64'(held_a));
        chk("t3_res_held",  64'(res_valid),  64'd1);
        res_ready = 1'b1;

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            in_valid    = ($urandom % 3) == 0;
            in_op_a     = $urandom;
            in_op_b     = $urandom;
            res_ready   = ($urandom % 4) != 0;
            stub_status = 4'($urandom);
            tick();
        end
        in_valid = 1'b0; res_ready = 1'b1;

        // 4: overflow counter saturation
        do_reset(2);
        stub_status = 4'b0100;
        in_valid = 1'b1;
        for (int i = 0; i < 300 * (HOLD + 3) + 20; i++) begin
            in_op_a = $urandom; in_op_b = $urandom;
            tick();
        end
        in_valid = 1'b0;
        chk("t4_ovf_sat", 64'(cnt_ovf), 64'd255);
        chk("t4_unf",     64'(cnt_unf), 64'd0);

        // 5: reset mid-HOLD with three entries queued
        do_reset(1);
        stub_status = 4'b0001;
        for (int i = 0; i < 4; i++) push_pair($urandom, $urandom);
        repeat (20) tick();
        chk("t5_queued", 64'(fifo_count), 64'd3);
        do_reset(1);
        chk("t5_busy",  64'(busy),       64'd0);
        chk("t5_count", 64'(fifo_count), 64'd0);
        chk("t5_rv",    64'(res_valid),  64'd0);
        chk("t5_opa",   64'(fpu_op_a),   64'd0);

        // 6: both flags in one result
        stub_status = 4'b1100;
        push_pair(32'h1234_5678, 32'h0F0F_0F0F);
        repeat (HOLD + 10) tick();
        chk("t6_ovf", 64'(cnt_ovf), 64'd1);
        chk("t6_unf", 64'(cnt_unf), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
